genie_elastic_buffer: RTL and testbench

Parametrised elastic buffer for valid/ready streaming links. It generalises the two-entry registered pipe stage to DEPTH entries and adds an occupancy output and a synchronous flush. Both o_ready and o_valid are driven from registers, so the block breaks every combinational path between its upstream and downstream ports. It sits on long or high-fanout interconnect links between endpoints and the crossbar, and in place of chains of pipe stages.

---
 rtl/genie_elastic_buffer.sv | 92 +++++++++
 tb/tb_genie_elastic_buffer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/genie_elastic_buffer.sv
// genie_elastic_buffer: DEPTH-entry elastic buffer for valid/ready links.
// o_ready and o_valid both come straight from registers, so no combinational
// path crosses the block in either direction. Storage is a circular buffer
// whose pointers wrap at DEPTH-1, so DEPTH need not be a power of two.
module genie_elastic_buffer #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [CW-1:0]    o_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // A single-entry buffer cannot keep a free slot while o_ready is high.
  generate
    if (DEPTH < 2) begin : g_depth_check
      $error("genie_elastic_buffer: DEPTH must be 2 or more");
    end
  endgenerate

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          ready_reg, ready_next;
  logic          valid_reg, valid_next;
  logic          push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign push    = i_valid && ready_reg;
  assign pop     = valid_reg && i_ready;
  assign o_ready = ready_reg;
  assign o_valid = valid_reg;
  assign o_count = count_reg;
  assign o_data  = mem[rd_ptr_reg];

  // Next-state: occupancy and pointers; a flush empties the buffer by
  // snapping the read pointer onto the (unadvanced) write pointer.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg + CW'(push) - CW'(pop);
    if (i_flush) begin
      count_next  = '0;
      rd_ptr_next = wr_ptr_reg;
    end else begin
      if (push) wr_ptr_next = ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_next = ptr_inc(rd_ptr_reg);
    end
    // Ready only while a slot stays free even if nothing drains next cycle.
    ready_next = (count_next < CW'(DEPTH));
    valid_next = (count_next != '0);
  end

  // Control state register; the async reset drops o_valid immediately.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ready_reg  <= 1'b1;
      valid_reg  <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      ready_reg  <= ready_next;
      valid_reg  <= valid_next;
    end
  end

  // Payload storage: written on push, not reset; a beat accepted during a
  // flush is dropped rather than stored.
  always_ff @(posedge i_clk) begin
    if (push && !i_flush) mem[wr_ptr_reg] <= i_data;
  end

endmodule

// File: tb/tb_genie_elastic_buffer.sv
// Directed bench for genie_elastic_buffer with DEPTH=4, 2 and 3 instances.
module tb_genie_elastic_buffer;

  logic clk;
  logic rst;

  // DEPTH=4 instance
  logic       d4_flush, d4_valid, d4_in_ready;
  logic [7:0] d4_data;
  logic       d4_out_ready, d4_out_valid;
  logic [7:0] d4_out_data;
  logic [2:0] d4_count;
  // DEPTH=2 instance
  logic       d2_flush, d2_valid, d2_in_ready;
  logic [7:0] d2_data;
  logic       d2_out_ready, d2_out_valid;
  logic [7:0] d2_out_data;
  logic [1:0] d2_count;
  // DEPTH=3 instance
  logic       d3_flush, d3_valid, d3_in_ready;
  logic [7:0] d3_data;
  logic       d3_out_ready, d3_out_valid;
  logic [7:0] d3_out_data;
  logic [1:0] d3_count;

  int errors = 0;
  int checks = 0;

  genie_elastic_buffer #(.WIDTH(8), .DEPTH(4)) u_d4 (
    .i_clk(clk), .i_reset(rst), .i_flush(d4_flush), .i_data(d4_data),
    .i_valid(d4_valid), .o_ready(d4_out_ready), .o_data(d4_out_data),
    .o_valid(d4_out_valid), .i_ready(d4_in_ready), .o_count(d4_count));

  genie_elastic_buffer #(.WIDTH(8), .DEPTH(2)) u_d2 (
    .i_clk(clk), .i_reset(rst), .i_flush(d2_flush), .i_data(d2_data),
    .i_valid(d2_valid), .o_ready(d2_out_ready), .o_data(d2_out_data),
    .o_valid(d2_out_valid), .i_ready(d2_in_ready), .o_count(d2_count));

  genie_elastic_buffer #(.WIDTH(8), .DEPTH(3)) u_d3 (
    .i_clk(clk), .i_reset(rst), .i_flush(d3_flush), .i_data(d3_data),
    .i_valid(d3_valid), .o_ready(d3_out_ready), .o_data(d3_out_data),
    .o_valid(d3_out_valid), .i_ready(d3_in_ready), .o_count(d3_count));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (d4_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid4: got %0b want 0", d4_out_valid); end
    checks++; if (d4_out_ready !== 1'b1) begin errors++; $display("FAIL reset_ready4: got %0b want 1", d4_out_ready); end
    checks++; if (d4_count !== 3'd0) begin errors++; $display("FAIL reset_count4: got %0d want 0", d4_count); end
    checks++; if (d2_out_valid !== 1'b0 || d2_count !== 2'd0) begin errors++; $display("FAIL reset_d2: got valid=%0b count=%0d want 0/0", d2_out_valid, d2_count); end
    checks++; if (d3_out_valid !== 1'b0 || d3_count !== 2'd0) begin errors++; $display("FAIL reset_d3: got valid=%0b count=%0d want 0/0", d3_out_valid, d3_count); end
    step();
    rst = 1'b0;
    step();
    $display("reset: done");
  endtask

  task automatic test_fill();
    logic [7:0] beats [4];
    beats[0] = 8'hA1; beats[1] = 8'hB2; beats[2] = 8'hC3; beats[3] = 8'hD4;
    d4_in_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      d4_valid = 1'b1;
      d4_data  = beats[k];
      step();
      $display("fill: push %0h count=%0d", beats[k], d4_count);
      checks++; if (d4_count !== 3'(k + 1)) begin errors++; $display("FAIL fill_count: got %0d want %0d", d4_count, k + 1); end
      checks++; if (d4_out_data !== 8'hA1 || d4_out_valid !== 1'b1) begin errors++; $display("FAIL fill_head: got %0h/%0b want a1/1", d4_out_data, d4_out_valid); end
      checks++; if (d4_out_ready !== (k < 3)) begin errors++; $display("FAIL fill_ready: got %0b want %0b", d4_out_ready, (k < 3)); end
    end
    // Beat E held on i_valid while full must not be taken.
    d4_data = 8'hE5;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (d4_count !== 3'd4 || d4_out_ready !== 1'b0) begin errors++; $display("FAIL fill_hold: got count=%0d ready=%0b want 4/0", d4_count, d4_out_ready); end
      checks++; if (d4_out_data !== 8'hA1) begin errors++; $display("FAIL fill_hold_data: got %0h want a1", d4_out_data); end
    end
    d4_valid    = 1'b0;
    d4_in_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (d4_out_valid !== 1'b1 || d4_out_data !== beats[k]) begin errors++; $display("FAIL fill_drain: got %0h/%0b want %0h/1", d4_out_data, d4_out_valid, beats[k]); end
      step();
      $display("fill: pop %0h", beats[k]);
      if (k == 0) begin
        checks++; if (d4_out_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_rise: got %0b want 1", d4_out_ready); end
      end
    end
    checks++; if (d4_out_valid !== 1'b0 || d4_count !== 3'd0) begin errors++; $display("FAIL fill_empty: got valid=%0b count=%0d want 0/0", d4_out_valid, d4_count); end
    d4_in_ready = 1'b0;
  endtask

  task automatic test_streaming();
    d2_in_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      d2_valid = 1'b1;
      d2_data  = 8'(i);
      step();
      $display("stream: beat %0d out=%0d count=%0d", i, d2_out_data, d2_count);
      checks++; if (d2_out_data !== 8'(i) || d2_out_valid !== 1'b1) begin errors++; $display("FAIL stream_data: got %0d/%0b want %0d/1", d2_out_data, d2_out_valid, i); end
      checks++; if (d2_count !== 2'd1 || d2_out_ready !== 1'b1) begin errors++; $display("FAIL stream_occ: got count=%0d ready=%0b want 1/1", d2_count, d2_out_ready); end
    end
    d2_valid = 1'b0;
    step();
    checks++; if (d2_count !== 2'd0 || d2_out_valid !== 1'b0) begin errors++; $display("FAIL stream_end: got count=%0d valid=%0b want 0/0", d2_count, d2_out_valid); end
    d2_in_ready = 1'b0;
  endtask

  task automatic test_wrap_stalls();
    logic [7:0] q [$];
    logic [7:0] exp_data;
    int sent = 0;
    int recv = 0;
    int model_count = 0;
    logic push, pop;
    for (int cyc = 0; cyc < 2000 && recv < 20; cyc++) begin
      d3_valid    = (sent < 20) && ($urandom_range(0, 3) != 0);
      d3_data     = 8'(100 + sent);
      d3_in_ready = ($urandom_range(0, 2) != 0);
      push = d3_valid && d3_out_ready;
      pop  = d3_out_valid && d3_in_ready;
      if (pop) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL wrap_spurious: got pop of %0d want no pop", d3_out_data);
        end else begin
          exp_data = q.pop_front();
          if (d3_out_data !== exp_data) begin errors++; $display("FAIL wrap_order: got %0d want %0d", d3_out_data, exp_data); end
        end
        recv++;
        $display("wrap: pop %0d", d3_out_data);
      end
      if (push) begin
        q.push_back(d3_data);
        sent++;
      end
      step();
      model_count = model_count + int'(push) - int'(pop);
      checks++; if (d3_count !== 2'(model_count)) begin errors++; $display("FAIL wrap_count: got %0d want %0d", d3_count, model_count); end
      checks++; if (d3_out_valid !== (model_count != 0) || d3_out_ready !== (model_count <= 2)) begin errors++; $display("FAIL wrap_flags: got valid=%0b ready=%0b count=%0d", d3_out_valid, d3_out_ready, model_count); end
    end
    checks++; if (recv != 20) begin errors++; $display("FAIL wrap_timeout: got %0d beats want 20", recv); end
    d3_valid    = 1'b0;
    d3_in_ready = 1'b0;
  endtask

  task automatic test_full_push_pop();
    d4_in_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      d4_valid = 1'b1;
      d4_data  = 8'(10 + k);
      step();
    end
    checks++; if (d4_count !== 3'd3 || d4_out_ready !== 1'b1) begin errors++; $display("FAIL pp_setup: got count=%0d ready=%0b want 3/1", d4_count, d4_out_ready); end
    d4_in_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      d4_data = 8'(13 + k);
      checks++; if (d4_out_data !== 8'(10 + k)) begin errors++; $display("FAIL pp_head: got %0d want %0d", d4_out_data, 10 + k); end
      step();
      $display("pushpop: in %0d out %0d count=%0d", 13 + k, 10 + k, d4_count);
      checks++; if (d4_count !== 3'd3 || d4_out_ready !== 1'b1) begin errors++; $display("FAIL pp_occ: got count=%0d ready=%0b want 3/1", d4_count, d4_out_ready); end
    end
    d4_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++; if (d4_out_data !== 8'(16 + k) || d4_out_valid !== 1'b1) begin errors++; $display("FAIL pp_drain: got %0d/%0b want %0d/1", d4_out_data, d4_out_valid, 16 + k); end
      step();
    end
    checks++; if (d4_count !== 3'd0) begin errors++; $display("FAIL pp_empty: got %0d want 0", d4_count); end
    d4_in_ready = 1'b0;
  endtask

  task automatic test_flush();
    d4_in_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      d4_valid = 1'b1;
      d4_data  = 8'(8'h20 + k);
      step();
    end
    d4_flush    = 1'b1;
    d4_data     = 8'h99;
    d4_in_ready = 1'b1;
    checks++; if (d4_out_valid !== 1'b1 || d4_out_data !== 8'h20 || d4_out_ready !== 1'b1) begin errors++; $display("FAIL flush_head: got %0h/%0b/%0b want 20/1/1", d4_out_data, d4_out_valid, d4_out_ready); end
    step();
    d4_flush    = 1'b0;
    d4_valid    = 1'b0;
    d4_in_ready = 1'b0;
    $display("flush: applied");
    checks++; if (d4_out_valid !== 1'b0 || d4_count !== 3'd0 || d4_out_ready !== 1'b1) begin errors++; $display("FAIL flush_state: got valid=%0b count=%0d ready=%0b want 0/0/1", d4_out_valid, d4_count, d4_out_ready); end
    d4_valid = 1'b1;
    d4_data  = 8'h55;
    step();
    d4_valid = 1'b0;
    checks++; if (d4_out_valid !== 1'b1 || d4_out_data !== 8'h55 || d4_count !== 3'd1) begin errors++; $display("FAIL flush_next: got %0h/%0b count=%0d want 55/1/1", d4_out_data, d4_out_valid, d4_count); end
    d4_in_ready = 1'b1;
    step();
    checks++; if (d4_count !== 3'd0 || d4_out_valid !== 1'b0) begin errors++; $display("FAIL flush_drain: got count=%0d valid=%0b want 0/0", d4_count, d4_out_valid); end
    d4_in_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    d4_in_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      d4_valid = 1'b1;
      d4_data  = 8'(8'h30 + k);
      step();
    end
    d4_valid = 1'b0;
    checks++; if (d4_count !== 3'd2 || d4_out_valid !== 1'b1) begin errors++; $display("FAIL areset_setup: got count=%0d valid=%0b want 2/1", d4_count, d4_out_valid); end
    #2;
    rst = 1'b1;
    #1;
    $display("areset: asserted mid-cycle");
    checks++; if (d4_out_valid !== 1'b0 || d4_count !== 3'd0 || d4_out_ready !== 1'b1) begin errors++; $display("FAIL areset_now: got valid=%0b count=%0d ready=%0b want 0/0/1", d4_out_valid, d4_count, d4_out_ready); end
    step();
    #2;
    rst = 1'b0;
    step();
    d4_valid = 1'b1;
    d4_data  = 8'h77;
    step();
    d4_valid = 1'b0;
    checks++; if (d4_out_valid !== 1'b1 || d4_out_data !== 8'h77 || d4_count !== 3'd1) begin errors++; $display("FAIL areset_resume: got %0h/%0b count=%0d want 77/1/1", d4_out_data, d4_out_valid, d4_count); end
    d4_in_ready = 1'b1;
    step();
    checks++; if (d4_count !== 3'd0 || d4_out_valid !== 1'b0) begin errors++; $display("FAIL areset_drain: got count=%0d valid=%0b want 0/0", d4_count, d4_out_valid); end
    d4_in_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    d4_flush = 1'b0; d4_valid = 1'b0; d4_in_ready = 1'b0; d4_data = 8'h00;
    d2_flush = 1'b0; d2_valid = 1'b0; d2_in_ready = 1'b0; d2_data = 8'h00;
    d3_flush = 1'b0; d3_valid = 1'b0; d3_in_ready = 1'b0; d3_data = 8'h00;
    test_reset();
    test_fill();
    test_streaming();
    test_wrap_stalls();
    test_full_push_pop();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
